touch_coord_latch: RTL and testbench

TOUCH_COORD_LATCH -- requirements
Module: touch_coord_latch

---
 rtl/touch_pkg.sv | 16 +
 rtl/touch_avg.sv | 53 +++++
 rtl/touch_coord_latch.sv | 208 ++++++++++++++++++++
 tb/tb_touch_coord_latch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// Shared types and constants for the touch coordinate latch:
// debounce state encoding and the "no touch" coordinate reported while released.
package touch_pkg;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } touch_state_e;

    // Reported coordinate while released, before truncation to the output widths
    localparam int NOTOUCH_X_RAW = 1000;
    localparam int NOTOUCH_Y_RAW = 1000;

endpackage

// File: rtl/touch_avg.sv
// Block averager for adjusted touch coordinates: emits sum >> AVG_LOG2 on the
// 2^AVG_LOG2-th accepted sample, then restarts. Used only with TOUCH_FILTER_EN.
module touch_avg
    import touch_pkg::*;
#(
    parameter int COORD_W  = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic               cclk,
    input  logic               rstb,
    input  logic               clr,
    input  logic               in_vld,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               out_vld,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y
);
    localparam int ACC_W = COORD_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_x, acc_y;
    logic [ACC_W-1:0]    sum_x, sum_y;
    logic [AVG_LOG2-1:0] cnt;

    // The block result includes the sample arriving this cycle, so it is ready combinationally
    assign sum_x   = acc_x + ACC_W'(in_x);
    assign sum_y   = acc_y + ACC_W'(in_y);
    assign out_vld = in_vld && (&cnt);
    assign out_x   = COORD_W'(sum_x >> AVG_LOG2);
    assign out_y   = COORD_W'(sum_y >> AVG_LOG2);

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (clr) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (in_vld) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
                acc_x <= '0;
                acc_y <= '0;
            end else begin
                acc_x <= sum_x;
                acc_y <= sum_y;
            end
        end
    end

endmodule

// File: rtl/touch_coord_latch.sv
// Debounced touch-panel coordinate latch, frozen once per TFT frame.
// Optional block averaging of coordinates is enabled by defining TOUCH_FILTER_EN.
module touch_coord_latch
    import touch_pkg::*;
#(
    parameter int COORD_W     = 12,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int X_OFFSET    = 150,
    parameter int Y_OFFSET    = 300,
    parameter int X_SHIFT     = 3,
    parameter int Y_SHIFT     = 4,
    parameter int X_MAX       = 479,
    parameter int Y_MAX       = 271,
    parameter int Z_THRESH    = 256,
    parameter int DEB_SAMPLES = 3,
    parameter int AVG_LOG2    = 2,
    parameter logic [X_W-1:0] NOTOUCH_X = X_W'(NOTOUCH_X_RAW),
    parameter logic [Y_W-1:0] NOTOUCH_Y = Y_W'(NOTOUCH_Y_RAW)
) (
    input  logic               cclk,
    input  logic               rstb,
    input  logic               touch_valid,
    input  logic [COORD_W-1:0] touch_x,
    input  logic [COORD_W-1:0] touch_y,
    input  logic [COORD_W-1:0] touch_z,
    input  logic               new_frame,
    output logic [X_W-1:0]     locked_x,
    output logic [Y_W-1:0]     locked_y,
    output logic               locked_pressed,
    output logic               press_evt,
    output logic               release_evt
);
    // The sample entering a pending state counts as the first of the run
    localparam int DEB_LAST = DEB_SAMPLES - 2;
    localparam int CNT_W    = (DEB_SAMPLES > 2) ? $clog2(DEB_SAMPLES) : 1;

    function automatic logic [COORD_W-1:0] sat_adj(input logic [COORD_W-1:0] raw,
                                                   input logic [COORD_W-1:0] off);
        return (raw >= off) ? raw - off : '0;
    endfunction

    function automatic logic [X_W-1:0] scale_x(input logic [COORD_W-1:0] a);
        logic [COORD_W-1:0] s;
        s = a >> X_SHIFT;
        if (s > COORD_W'(X_MAX)) s = COORD_W'(X_MAX);
        return X_W'(s);
    endfunction

    function automatic logic [Y_W-1:0] scale_y(input logic [COORD_W-1:0] a);
        logic [COORD_W-1:0] s;
        s = a >> Y_SHIFT;
        if (s > COORD_W'(Y_MAX)) s = COORD_W'(Y_MAX);
        return Y_W'(s);
    endfunction

    touch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample_pressed, press_d, release_d, qualify, is_pressed;

    assign sample_pressed = (touch_z >= COORD_W'(Z_THRESH));
    assign is_pressed     = (state_q == PRESSED) || (state_q == REL_PEND);
    // A coordinate is trusted only from a pressed sample that leaves the FSM in PRESSED
    assign qualify        = touch_valid && sample_pressed && (state_d == PRESSED);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (touch_valid) begin
            unique case (state_q)
                RELEASED: begin
                    if (sample_pressed) begin
                        state_d = PRESS_PEND;
                        cnt_d   = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!sample_pressed) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_W'(DEB_LAST)) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sample_pressed) begin
                        state_d = REL_PEND;
                        cnt_d   = '0;
                    end
                end
                REL_PEND: begin
                    if (sample_pressed) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_W'(DEB_LAST)) begin
                        state_d   = RELEASED;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= RELEASED;
            cnt_q       <= '0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_evt   <= press_d;
            release_evt <= release_d;
        end
    end

    // ---- stage p0: offset-adjusted coordinates of a qualifying sample
    logic               vld_p0;
    logic [COORD_W-1:0] adj_x_p0, adj_y_p0;

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) vld_p0 <= 1'b0;
        else       vld_p0 <= qualify;
    end

    always_ff @(posedge cclk) begin
        if (qualify) begin
            adj_x_p0 <= sat_adj(touch_x, COORD_W'(X_OFFSET));
            adj_y_p0 <= sat_adj(touch_y, COORD_W'(Y_OFFSET));
        end
    end

    logic               upd_vld;
    logic [COORD_W-1:0] upd_x, upd_y;

`ifdef TOUCH_FILTER_EN
    logic avg_clr;
    assign avg_clr = (state_q == RELEASED) || (state_q == PRESS_PEND);

    touch_avg #(
        .COORD_W (COORD_W),
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .cclk   (cclk),
        .rstb   (rstb),
        .clr    (avg_clr),
        .in_vld (vld_p0),
        .in_x   (adj_x_p0),
        .in_y   (adj_y_p0),
        .out_vld(upd_vld),
        .out_x  (upd_x),
        .out_y  (upd_y)
    );
`else
    assign upd_vld = vld_p0;
    assign upd_x   = adj_x_p0;
    assign upd_y   = adj_y_p0;
`endif

    // ---- stage p1: scaled, clamped current coordinate
    logic [X_W-1:0] cur_x_p1;
    logic [Y_W-1:0] cur_y_p1;

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            cur_x_p1 <= '0;
            cur_y_p1 <= '0;
        end else if (upd_vld) begin
            cur_x_p1 <= scale_x(upd_x);
            cur_y_p1 <= scale_y(upd_y);
        end
    end

    // Frame latch samples cur_*_p1 before any same-cycle update; nf_q resets high
    logic nf_q, frame_rise;
    assign frame_rise = new_frame && !nf_q;

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            nf_q           <= 1'b1;
            locked_x       <= NOTOUCH_X;
            locked_y       <= NOTOUCH_Y;
            locked_pressed <= 1'b0;
        end else begin
            nf_q <= new_frame;
            if (frame_rise) begin
                locked_pressed <= is_pressed;
                locked_x       <= is_pressed ? cur_x_p1 : NOTOUCH_X;
                locked_y       <= is_pressed ? cur_y_p1 : NOTOUCH_Y;
            end
        end
    end

endmodule

// File: tb/tb_touch_coord_latch.sv
// Self-checking bench for touch_coord_latch: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_touch_coord_latch;

    localparam int DEB  = 3;
    localparam int NAVG = 4;
    localparam int NT_X = 1000 % 1024;
    localparam int NT_Y = 1000 % 512;

    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        touch_valid = 1'b0;
    logic        new_frame = 1'b0;
    logic [11:0] touch_x = '0, touch_y = '0, touch_z = '0;
    logic [9:0]  locked_x;
    logic [8:0]  locked_y;
    logic        locked_pressed, press_evt, release_evt;

    always #5 cclk = ~cclk;

    touch_coord_latch dut (
        .cclk          (cclk),
        .rstb          (rstb),
        .touch_valid   (touch_valid),
        .touch_x       (touch_x),
        .touch_y       (touch_y),
        .touch_z       (touch_z),
        .new_frame     (new_frame),
        .locked_x      (locked_x),
        .locked_y      (locked_y),
        .locked_pressed(locked_pressed),
        .press_evt     (press_evt),
        .release_evt   (release_evt)
    );

    int n_chk = 0;
    int n_pass = 0;
    int pevt_cnt = 0;
    int revt_cnt = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Behavioural model: stable press flag plus a run of disagreeing samples
    bit m_stable, m_pend, m_lp, m_pe, m_re, m_nfp;
    int m_run, m_px, m_py, m_cx, m_cy, m_lx, m_ly;
    int avg_x[$], avg_y[$];

    function automatic int adj(input int raw, input int off);
        return (raw >= off) ? raw - off : 0;
    endfunction

    function automatic int scl(input int a, input int sh, input int mx, input int m);
        int v;
        v = a >> sh;
        if (v > mx) v = mx;
        return v % m;
    endfunction

    task automatic model_reset();
        m_stable = 0; m_run = 0; m_pend = 0; m_px = 0; m_py = 0;
        m_cx = 0; m_cy = 0; m_lx = NT_X; m_ly = NT_Y; m_lp = 0;
        m_pe = 0; m_re = 0; m_nfp = 1;
        avg_x.delete(); avg_y.delete();
    endtask

    task automatic model_edge();
        bit pr;
        int ax, ay, sx, sy;
        m_pe = 0;
        m_re = 0;
        if (new_frame && !m_nfp) begin
            m_lp = m_stable;
            m_lx = m_stable ? m_cx : NT_X;
            m_ly = m_stable ? m_cy : NT_Y;
        end
        m_nfp = new_frame;
        if (m_pend) begin
            m_cx = m_px;
            m_cy = m_py;
            m_pend = 0;
        end
        if (touch_valid) begin
            pr = (int'(touch_z) >= 256);
            if (pr == m_stable) m_run = 0;
            else begin
                m_run++;
                if (m_run >= DEB) begin
                    m_stable = pr;
                    m_run = 0;
                    if (pr) m_pe = 1;
                    else begin
                        m_re = 1;
                        avg_x.delete(); avg_y.delete();
                    end
                end
            end
            if (pr && m_stable) begin
                ax = adj(int'(touch_x), 150);
                ay = adj(int'(touch_y), 300);
`ifdef TOUCH_FILTER_EN
                avg_x.push_back(ax);
                avg_y.push_back(ay);
                if (avg_x.size() == NAVG) begin
                    sx = 0; sy = 0;
                    foreach (avg_x[i]) begin sx += avg_x[i]; sy += avg_y[i]; end
                    m_px = scl(sx / NAVG, 3, 479, 1024);
                    m_py = scl(sy / NAVG, 4, 271, 512);
                    m_pend = 1;
                    avg_x.delete(); avg_y.delete();
                end
`else
                sx = ax; sy = ay;
                m_px = scl(sx, 3, 479, 1024);
                m_py = scl(sy, 4, 271, 512);
                m_pend = 1;
`endif
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_lx"},  int'(locked_x), m_lx);
        chk({tag, "_ly"},  int'(locked_y), m_ly);
        chk({tag, "_lp"},  int'(locked_pressed), int'(m_lp));
        chk({tag, "_pev"}, int'(press_evt), int'(m_pe));
        chk({tag, "_rev"}, int'(release_evt), int'(m_re));
    endtask

    task automatic step(input bit tv, input int x, input int y, input int z, input bit nf);
        @(negedge cclk);
        touch_valid = tv;
        touch_x = 12'(x);
        touch_y = 12'(y);
        touch_z = 12'(z);
        new_frame = nf;
        @(posedge cclk);
        model_edge();
        #1;
        check_outputs("cyc");
        pevt_cnt += int'(press_evt);
        revt_cnt += int'(release_evt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic frame_pulse();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge cclk);
        rstb = 1'b0;
        touch_valid = 1'b0;
        new_frame = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        @(posedge cclk);
        #1;
        check_outputs("rst_hold");
        @(negedge cclk);
        rstb = 1'b1;
    endtask

    initial begin
        bit finger, nf;
        int z;
        model_reset();
        repeat (2) @(posedge cclk);
        #1;
        chk("rst_x", int'(locked_x), NT_X);
        chk("rst_y", int'(locked_y), NT_Y);
        chk("rst_p", int'(locked_pressed), 0);
        chk("rst_pev", int'(press_evt), 0);
        @(negedge cclk);
        rstb = 1'b1;
        idle(2);

        // Debounced press followed by a frame latch
        pevt_cnt = 0;
        repeat (3) step(1, 950, 1388, 1024, 0);
        idle(2);
        frame_pulse();
`ifndef TOUCH_FILTER_EN
        chk("r018_x", int'(locked_x), 100);
        chk("r018_y", int'(locked_y), 68);
`endif
        chk("r018_p", int'(locked_pressed), 1);
        chk("r018_pev", pevt_cnt, 1);

        // Offset underflow saturates, then x clamps to X_MAX
        step(1, 100, 4095, 1024, 0);
        idle(2);
        frame_pulse();
`ifndef TOUCH_FILTER_EN
        chk("r019_x", int'(locked_x), 0);
        chk("r019_y", int'(locked_y), (4095 - 300) >> 4);
`endif
        step(1, 4095, 4095, 1024, 0);
        idle(2);
        frame_pulse();
`ifndef TOUCH_FILTER_EN
        chk("r019_xmax", int'(locked_x), 479);
`endif

        // Release, then an aborted press
        repeat (3) step(1, 500, 500, 0, 0);
        pevt_cnt = 0;
        repeat (2) step(1, 950, 1388, 1024, 0);
        step(1, 950, 1388, 255, 0);
        idle(2);
        frame_pulse();
        chk("r020_x", int'(locked_x), 1000);
        chk("r020_y", int'(locked_y), 488);
        chk("r020_p", int'(locked_pressed), 0);
        chk("r020_pev", pevt_cnt, 0);

        // Pressed run at exactly the threshold; last four samples form one average
        repeat (2) step(1, 950, 1388, 256, 0);
        step(1, 950, 1388, 256, 0);
        step(1, 958, 1388, 256, 0);
        step(1, 966, 1388, 256, 0);
        step(1, 974, 1388, 256, 0);
        idle(2);
        frame_pulse();
`ifdef TOUCH_FILTER_EN
        chk("r021_x", int'(locked_x), 101);
`else
        chk("r021_x", int'(locked_x), 103);
`endif

        // new_frame held high while coordinates move: one latch only
        for (int i = 0; i < 10; i++) step(1, 1000 + 8 * i, 1400 + 16 * i, 2000, 1);
`ifdef TOUCH_FILTER_EN
        chk("r022_x", int'(locked_x), 101);
`else
        chk("r022_x", int'(locked_x), 103);
`endif
        frame_pulse();

        // Reset while a release is pending
        step(1, 900, 900, 10, 0);
        do_reset();
        revt_cnt = 0;
        chk("r023_x", int'(locked_x), NT_X);
        chk("r023_p", int'(locked_pressed), 0);
        repeat (2) step(1, 900, 900, 10, 0);
        chk("r023_rev", revt_cnt, 0);

        // Random phase
        finger = 0;
        nf = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) finger = ~finger;
            if ($urandom_range(0, 3) == 0) nf = ~nf;
            if (finger) z = ($urandom_range(0, 7) == 0) ? 256 : int'($urandom_range(200, 4095));
            else        z = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 300));
            step($urandom_range(0, 2) != 0, int'($urandom_range(0, 4095)),
                 int'($urandom_range(0, 4095)), z, nf);
            if (i == 400) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
